// File: rtl/cla_sum_stage.sv
// cla_sum_stage: registered sum/flag stage with carry re-check behind a 2-entry valid/ready skid buffer
// Ports: clk, rst (sync, active high); in_valid/in_ready with a, b, cin, c (carry out of each bit);
//        out_valid/out_ready with s, cout, ovf, zero, neg; clr_err/carry_err sticky carry check; txn_count pops.
module cla_sum_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  input  logic             clr_err,
  output logic             carry_err,
  output logic [CNT_W-1:0] txn_count
);
  localparam int EW = WIDTH + 4;
  logic [WIDTH-1:0] p, g, e, sum;
  logic [EW-1:0] word, head;
  logic [EW-1:0] mem [2];
  logic wp, rp, push, pop;
  logic [1:0] cnt;
  always_comb begin
    p = a ^ b;
    g = a & b;
    e = '0;
    e[0] = g[0] | (p[0] & cin);
    for (int i = 1; i < WIDTH; i++) e[i] = g[i] | (p[i] & e[i-1]);
    // results deliberately use the supplied carries, not the recomputed ones
    sum = p ^ {c[WIDTH-2:0], cin};
    word = {sum, c[WIDTH-1], c[WIDTH-1] ^ c[WIDTH-2], ~|sum, sum[WIDTH-1]};
  end
  assign in_ready = (cnt != 2'd2) && !rst;
  assign out_valid = cnt != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign head = mem[rp];
  // outputs read as zero whenever the buffer is empty, including after reset
  assign {s, cout, ovf, zero, neg} = out_valid ? head : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      txn_count <= '0;
      carry_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= word;
        wp <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
        txn_count <= txn_count + 1'b1;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
      carry_err <= clr_err ? 1'b0 : (carry_err | (push && e != c));
    end
  end
endmodule

// File: tb/tb_cla_sum_stage.sv
// tb_cla_sum_stage: directed table-driven checks plus buffer, error and reset sequences
module tb_cla_sum_stage;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 0;
  logic [15:0] a = 0, b = 0, c = 0, s, txn_count;
  logic cout, ovf, zero, neg, clr_err = 0, carry_err;
  int checks = 0, failures = 0;

  cla_sum_stage #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg),
    .clr_err(clr_err), .carry_err(carry_err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic cin;
    logic [15:0] s;
    logic cout, ovf, zero, neg;
  } vec_t;

  vec_t vt [7];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] carries(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] t;
    logic [15:0] m, r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      m = 16'((32'd2 << i) - 1);
      t = {1'b0, x & m} + {1'b0, y & m} + 17'(ci);
      r[i] = t[i+1];
    end
    return r;
  endfunction

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic ci);
    a = x;
    b = y;
    cin = ci;
    c = carries(x, y, ci);
    in_valid = 1;
  endtask

  initial begin
    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[6] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
    step;
    step;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_s", 32'(s), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_txn", 32'(txn_count), 0);
    chk("rst_err", 32'(carry_err), 0);
    rst = 0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 1);
    out_ready = 1;
    for (int k = 0; k < 7; k++) begin
      drive(vt[k].a, vt[k].b, vt[k].cin);
      step;
      in_valid = 0;
      chk($sformatf("v%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("v%0d_s", k), 32'(s), 32'(vt[k].s));
      chk($sformatf("v%0d_cout", k), 32'(cout), 32'(vt[k].cout));
      chk($sformatf("v%0d_ovf", k), 32'(ovf), 32'(vt[k].ovf));
      chk($sformatf("v%0d_zero", k), 32'(zero), 32'(vt[k].zero));
      chk($sformatf("v%0d_neg", k), 32'(neg), 32'(vt[k].neg));
      step;
      chk($sformatf("v%0d_drained", k), 32'(out_valid), 0);
    end
    chk("txn_after_table", 32'(txn_count), 7);
    chk("err_clean", 32'(carry_err), 0);
    // backpressure: W1, W2 fill, W3 held
    out_ready = 0;
    drive(16'h0011, 16'h0000, 0);
    step;
    chk("bp_ready_w1", 32'(in_ready), 1);
    drive(16'h0022, 16'h0000, 0);
    step;
    chk("bp_ready_w2", 32'(in_ready), 0);
    drive(16'h0033, 16'h0000, 0);
    step;
    chk("bp_hold_s1", 32'(s), 32'h0011);
    step;
    chk("bp_hold_s2", 32'(s), 32'h0011);
    chk("bp_hold_ready", 32'(in_ready), 0);
    out_ready = 1;
    step;
    chk("bp_w2", 32'(s), 32'h0022);
    step;
    in_valid = 0;
    chk("bp_w3", 32'(s), 32'h0033);
    step;
    chk("bp_empty", 32'(out_valid), 0);
    chk("bp_txn", 32'(txn_count), 10);
    // streaming push+pop at cnt=1
    out_ready = 0;
    drive(16'h0000, 16'h0000, 0);
    step;
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      drive(16'(k * 16'h0100), 16'(k), 0);
      step;
      chk($sformatf("st%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("st%0d_s", k), 32'(s), 32'(k * 16'h0101));
    end
    in_valid = 0;
    step;
    chk("st_empty", 32'(out_valid), 0);
    chk("st_txn", 32'(txn_count), 15);
    // carry error: bit 5 flipped
    drive(16'h1234, 16'h4321, 1);
    c = c ^ 16'h0020;
    step;
    in_valid = 0;
    chk("err_set", 32'(carry_err), 1);
    step;
    step;
    chk("err_sticky", 32'(carry_err), 1);
    clr_err = 1;
    drive(16'h1234, 16'h4321, 1);
    c = c ^ 16'h0020;
    step;
    in_valid = 0;
    clr_err = 0;
    chk("err_clr_priority", 32'(carry_err), 0);
    step;
    chk("err_cleared", 32'(carry_err), 0);
    chk("err_txn", 32'(txn_count), 17);
    // reset with two words buffered
    out_ready = 0;
    drive(16'h0001, 16'h0001, 0);
    step;
    step;
    in_valid = 0;
    chk("full_ready", 32'(in_ready), 0);
    rst = 1;
    step;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_txn", 32'(txn_count), 0);
    chk("midrst_ready", 32'(in_ready), 0);
    rst = 0;
    #1;
    chk("midrst_ready_after", 32'(in_ready), 1);
    // counter wrap
    out_ready = 1;
    drive(16'h0000, 16'h0000, 0);
    for (int k = 0; k < 65536; k++) step;
    in_valid = 0;
    chk("wrap_ffff", 32'(txn_count), 32'hFFFF);
    step;
    chk("wrap_zero", 32'(txn_count), 0);
    chk("wrap_empty", 32'(out_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
